// File: rtl/mem_writeback_stage.sv
// Memory/write-back stage: req/ack data-memory read with timeout,
// write-back source select and register-file write strobes.
module mem_writeback_stage #(
  parameter int          ACK_TIMEOUT = 64,
  parameter logic [15:0] ERR_VALUE   = 16'hDEAD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        reg_wr_en_1_in,
  input  logic        reg_wr_en_2_in,
  input  logic [2:0]  buff_ctrl_in,
  input  logic [3:0]  reg_wr_sel_in,
  input  logic [15:0] mem_addr_in,
  input  logic [15:0] alu_in,
  input  logic [15:0] imm_in,
  input  logic [15:0] pc_in,
  input  logic [4:0]  flags_in,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic        rf_wr_en_1,
  output logic [3:0]  rf_wr_sel,
  output logic [15:0] rf_wr_data,
  output logic        rf_wr_en_2,
  output logic [4:0]  rf_flags,
  output logic        mem_err
);

  localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WB
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic        op_en1;
  logic        op_en2;
  logic [2:0]  op_buff;
  logic [3:0]  op_sel;
  logic [15:0] op_alu;
  logic [15:0] op_imm;
  logic [15:0] op_pc;
  logic [4:0]  op_flags;

  logic        timeout;
  logic        c_en1;
  logic        c_en2;
  logic        c_err;
  logic [3:0]  c_sel;
  logic [15:0] c_data;
  logic [4:0]  c_flags;

  function automatic logic [15:0] wb_mux(
    input logic [2:0]  buff,
    input logic [15:0] alu,
    input logic [15:0] imm,
    input logic [15:0] pc,
    input logic [15:0] mdata
  );
    logic [15:0] r;
    case (buff)
      3'b001:  r = mdata;
      3'b010:  r = imm;
      3'b011:  r = pc + 16'd1;
      3'b100:  r = {alu[7:0], alu[15:8]};
      default: r = alu;
    endcase
    return r;
  endfunction

  assign timeout = (ACK_TIMEOUT > 0) &&
                   (int'(cnt) == ACK_TIMEOUT - 1);

  assign stall = !reset &&
                 ((state == WAIT_ACK) || mem_read_in);

  // What gets written to the register file at the coming edge
  always_comb begin
    c_en1   = 1'b0;
    c_en2   = 1'b0;
    c_err   = 1'b0;
    c_sel   = reg_wr_sel_in;
    c_flags = flags_in;
    c_data  = wb_mux(buff_ctrl_in, alu_in, imm_in,
                     pc_in, 16'h0000);
    if (state == WAIT_ACK) begin
      c_sel   = op_sel;
      c_flags = op_flags;
      c_data  = wb_mux(op_buff, op_alu, op_imm,
                       op_pc, mem_rdata);
      if (mem_ack) begin
        c_en1 = op_en1;
        c_en2 = op_en2;
      end else if (timeout) begin
        c_en1  = op_en1;
        c_en2  = op_en2;
        c_err  = 1'b1;
        c_data = ERR_VALUE;
      end
    end else if (!mem_read_in) begin
      c_en1 = reg_wr_en_1_in;
      c_en2 = reg_wr_en_2_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_err    <= 1'b0;
      rf_wr_en_1 <= 1'b0;
      rf_wr_en_2 <= 1'b0;
      rf_wr_sel  <= '0;
      rf_wr_data <= '0;
      rf_flags   <= '0;
      op_en1     <= 1'b0;
      op_en2     <= 1'b0;
      op_buff    <= '0;
      op_sel     <= '0;
      op_alu     <= '0;
      op_imm     <= '0;
      op_pc      <= '0;
      op_flags   <= '0;
    end else begin
      rf_wr_en_1 <= c_en1;
      rf_wr_en_2 <= c_en2;
      mem_err    <= c_err;
      if (c_en1) begin
        rf_wr_sel  <= c_sel;
        rf_wr_data <= c_data;
      end
      if (c_en2) begin
        rf_flags <= c_flags;
      end
      unique case (state)
        WAIT_ACK: begin
          if (mem_ack || timeout) begin
            mem_req <= 1'b0;
            state   <= WB;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (mem_read_in) begin
            op_en1   <= reg_wr_en_1_in;
            op_en2   <= reg_wr_en_2_in;
            op_buff  <= buff_ctrl_in;
            op_sel   <= reg_wr_sel_in;
            op_alu   <= alu_in;
            op_imm   <= imm_in;
            op_pc    <= pc_in;
            op_flags <= flags_in;
            mem_req  <= 1'b1;
            mem_addr <= mem_addr_in;
            cnt      <= '0;
            state    <= WAIT_ACK;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Bench for mem_writeback_stage: directed cases with literal
// expectations, then randomized traffic against a behavioural model.
module tb_mem_writeback_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_in;
  logic        reg_wr_en_1_in;
  logic        reg_wr_en_2_in;
  logic [2:0]  buff_ctrl_in;
  logic [3:0]  reg_wr_sel_in;
  logic [15:0] mem_addr_in;
  logic [15:0] alu_in;
  logic [15:0] imm_in;
  logic [15:0] pc_in;
  logic [4:0]  flags_in;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        stall;
  logic        rf_wr_en_1;
  logic [3:0]  rf_wr_sel;
  logic [15:0] rf_wr_data;
  logic        rf_wr_en_2;
  logic [4:0]  rf_flags;
  logic        mem_err;

  int vectors = 0;
  int miscompares = 0;

  mem_writeback_stage #(
    .ACK_TIMEOUT(TO),
    .ERR_VALUE  (16'hDEAD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read_in   (mem_read_in),
    .reg_wr_en_1_in(reg_wr_en_1_in),
    .reg_wr_en_2_in(reg_wr_en_2_in),
    .buff_ctrl_in  (buff_ctrl_in),
    .reg_wr_sel_in (reg_wr_sel_in),
    .mem_addr_in   (mem_addr_in),
    .alu_in        (alu_in),
    .imm_in        (imm_in),
    .pc_in         (pc_in),
    .flags_in      (flags_in),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .stall         (stall),
    .rf_wr_en_1    (rf_wr_en_1),
    .rf_wr_sel     (rf_wr_sel),
    .rf_wr_data    (rf_wr_data),
    .rf_wr_en_2    (rf_wr_en_2),
    .rf_flags      (rf_flags),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  // Model: a pending read record plus how long it has waited
  bit          m_busy;
  int          m_wait;
  bit          p_en1, p_en2;
  logic [2:0]  p_buff;
  logic [3:0]  p_sel;
  logic [15:0] p_alu, p_imm, p_pc;
  logic [4:0]  p_flags;

  logic        e_req, e_en1, e_en2, e_err;
  logic [15:0] e_addr, e_data;
  logic [3:0]  e_sel;
  logic [4:0]  e_flags;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] src(
    input logic [2:0] b, input logic [15:0] alu,
    input logic [15:0] imm, input logic [15:0] pc,
    input logic [15:0] md);
    if (b == 3'd1) return md;
    if (b == 3'd2) return imm;
    if (b == 3'd3) return pc + 16'd1;
    if (b == 3'd4) return {alu[7:0], alu[15:8]};
    return alu;
  endfunction

  task automatic m_reset();
    m_busy = 0; m_wait = 0;
    e_req = 0; e_en1 = 0; e_en2 = 0; e_err = 0;
    e_addr = 0; e_data = 0; e_sel = 0; e_flags = 0;
  endtask

  task automatic commit(input bit en1, input bit en2,
                        input logic [3:0] sel,
                        input logic [15:0] d,
                        input logic [4:0] fl,
                        input bit err);
    e_en1 = en1;
    e_en2 = en2;
    e_err = err;
    if (en1) begin e_sel = sel; e_data = d; end
    if (en2) e_flags = fl;
  endtask

  task automatic m_step();
    e_en1 = 0; e_en2 = 0; e_err = 0;
    if (m_busy) begin
      if (mem_ack) begin
        commit(p_en1, p_en2, p_sel,
               src(p_buff, p_alu, p_imm, p_pc, mem_rdata),
               p_flags, 0);
        m_busy = 0; e_req = 0;
      end else if (m_wait == TO - 1) begin
        commit(p_en1, p_en2, p_sel, 16'hDEAD, p_flags, 1);
        m_busy = 0; e_req = 0;
      end else begin
        m_wait++;
      end
    end else if (mem_read_in) begin
      p_en1 = reg_wr_en_1_in; p_en2 = reg_wr_en_2_in;
      p_buff = buff_ctrl_in; p_sel = reg_wr_sel_in;
      p_alu = alu_in; p_imm = imm_in; p_pc = pc_in;
      p_flags = flags_in;
      m_busy = 1; m_wait = 0;
      e_req = 1; e_addr = mem_addr_in;
    end else begin
      commit(reg_wr_en_1_in, reg_wr_en_2_in, reg_wr_sel_in,
             src(buff_ctrl_in, alu_in, imm_in, pc_in, 16'h0),
             flags_in, 0);
    end
  endtask

  task automatic compare();
    chk("stall", 32'(stall), 32'(m_busy || mem_read_in));
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("en1", 32'(rf_wr_en_1), 32'(e_en1));
    chk("en2", 32'(rf_wr_en_2), 32'(e_en2));
    chk("err", 32'(mem_err), 32'(e_err));
    chk("sel", 32'(rf_wr_sel), 32'(e_sel));
    chk("data", 32'(rf_wr_data), 32'(e_data));
    chk("flags", 32'(rf_flags), 32'(e_flags));
  endtask

  task automatic tick();
    #1;
    compare();
    m_step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    mem_read_in = 0; reg_wr_en_1_in = 0; reg_wr_en_2_in = 0;
    buff_ctrl_in = 0; reg_wr_sel_in = 0; mem_addr_in = 0;
    alu_in = 0; imm_in = 0; pc_in = 0; flags_in = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic rd_op(input logic [15:0] a,
                       input logic [3:0] s);
    idle_in();
    mem_read_in = 1; reg_wr_en_1_in = 1;
    buff_ctrl_in = 3'd1; reg_wr_sel_in = s; mem_addr_in = a;
  endtask

  initial begin
    idle_in();
    reset = 1;
    m_reset();
    #1;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_data", 32'(rf_wr_data), 0);
    chk("rst_en1", 32'(rf_wr_en_1), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    tick();

    reg_wr_en_1_in = 1; alu_in = 16'h1234; reg_wr_sel_in = 3;
    tick();
    idle_in();
    chk("alu_en1", 32'(rf_wr_en_1), 1);
    chk("alu_sel", 32'(rf_wr_sel), 3);
    chk("alu_data", 32'(rf_wr_data), 32'h1234);
    chk("alu_stall", 32'(stall), 0);
    tick();

    rd_op(16'h0040, 5);
    tick();
    idle_in();
    chk("rd_req", 32'(mem_req), 1);
    chk("rd_addr", 32'(mem_addr), 32'h0040);
    tick();
    tick();
    mem_ack = 1; mem_rdata = 16'hBEEF;
    tick();
    idle_in();
    chk("rd_en1", 32'(rf_wr_en_1), 1);
    chk("rd_data", 32'(rf_wr_data), 32'hBEEF);
    chk("rd_sel", 32'(rf_wr_sel), 5);
    chk("rd_req_off", 32'(mem_req), 0);
    tick();

    rd_op(16'h0100, 7);
    tick();
    idle_in();
    repeat (TO) tick();
    chk("to_err", 32'(mem_err), 1);
    chk("to_data", 32'(rf_wr_data), 32'hDEAD);
    chk("to_req", 32'(mem_req), 0);
    tick();
    chk("to_err_pulse", 32'(mem_err), 0);

    reg_wr_en_1_in = 1; buff_ctrl_in = 3'd3; pc_in = 16'hFFFF;
    tick();
    chk("pc_wrap", 32'(rf_wr_data), 0);
    idle_in();
    reg_wr_en_1_in = 1; buff_ctrl_in = 3'd4; alu_in = 16'h12AB;
    tick();
    chk("bswap", 32'(rf_wr_data), 32'hAB12);
    idle_in();
    reg_wr_en_2_in = 1; flags_in = 5'h15;
    tick();
    chk("flags", 32'(rf_flags), 32'h15);
    chk("flags_en2", 32'(rf_wr_en_2), 1);
    idle_in();

    rd_op(16'h0200, 2);
    tick();
    idle_in();
    mem_ack = 1; mem_rdata = 16'h1111;
    tick();
    chk("b2b_a", 32'(rf_wr_data), 32'h1111);
    rd_op(16'h0300, 9);
    tick();
    idle_in();
    chk("b2b_req", 32'(mem_req), 1);
    chk("b2b_addr", 32'(mem_addr), 32'h0300);
    mem_ack = 1; mem_rdata = 16'h2222;
    tick();
    idle_in();
    chk("b2b_b", 32'(rf_wr_data), 32'h2222);
    chk("b2b_bsel", 32'(rf_wr_sel), 9);

    rd_op(16'h0400, 4);
    tick();
    idle_in();
    tick();
    mem_read_in = 1;
    reset = 1;
    #1;
    chk("mid_rst_req", 32'(mem_req), 0);
    chk("mid_rst_stall", 32'(stall), 0);
    m_reset();
    @(negedge clk);
    reset = 0;
    idle_in();
    mem_ack = 1; mem_rdata = 16'h5555;
    tick();
    idle_in();
    chk("post_rst_en1", 32'(rf_wr_en_1), 0);
    tick();

    for (int i = 0; i < 3000; i++) begin
      mem_read_in    = ($urandom_range(3) == 0);
      reg_wr_en_1_in = 1'($urandom);
      reg_wr_en_2_in = 1'($urandom);
      buff_ctrl_in   = 3'($urandom);
      reg_wr_sel_in  = 4'($urandom);
      mem_addr_in    = 16'($urandom);
      alu_in         = 16'($urandom);
      imm_in         = 16'($urandom);
      pc_in          = ($urandom_range(7) == 0) ?
                       16'hFFFF : 16'($urandom);
      flags_in       = 5'($urandom);
      mem_rdata      = 16'($urandom);
      mem_ack        = m_busy ? ($urandom_range(9) < 3)
                              : ($urandom_range(9) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
